// File: rtl/stf_sequencer_pkg.sv
// stf_sequencer_pkg
// Shared constants and types for the STF sequencer slice.
//   STF_PERIOD / STF_ADDR_W : depth and address width of the STF ROM
//   IQ_W, I_*/Q_*           : packed sample width and I/Q field positions
//   state_t                 : sequencer FSM state
package stf_sequencer_pkg;

  localparam int unsigned STF_PERIOD = 16;
  localparam int unsigned STF_ADDR_W = 4;

  localparam int unsigned IQ_W      = 32;
  localparam int unsigned IQ_HALF_W = 16;
  localparam int unsigned I_MSB     = 31;
  localparam int unsigned I_LSB     = 16;
  localparam int unsigned Q_MSB     = 15;
  localparam int unsigned Q_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/stf_sequencer_iq_half_shift.sv
// iq_half_shift
// Combinational halving of a packed I/Q sample: I and Q are each
// arithmetic-shifted right by one (sign kept, rounds toward -inf).
// Only instantiated when STF_WINDOW_EN is defined.
// Ports:
//   din  : packed sample in, I [31:16], Q [15:0]
//   dout : halved sample, same packing
module iq_half_shift
  import stf_sequencer_pkg::*;
(
  input  logic [IQ_W-1:0] din,
  output logic [IQ_W-1:0] dout
);

  always_comb begin
    dout              = '0;
    dout[I_MSB:I_LSB] = IQ_HALF_W'($signed(din[I_MSB:I_LSB]) >>> 1);
    dout[Q_MSB:Q_LSB] = IQ_HALF_W'($signed(din[Q_MSB:Q_LSB]) >>> 1);
  end

endmodule

// File: rtl/stf_sequencer.sv
// stf_sequencer
// Replays the 16-sample STF period NUM_REP times from an external
// combinational ROM onto a registered valid/ready sample stream.
// Optional feature macro: STF_WINDOW_EN halves the first and last sample
// of each sequence (edge windowing); latency is unchanged.
// Ports:
//   clk         : TX clock, rising edge
//   phy_tx_arst : asynchronous active-high reset
//   start       : one-cycle start pulse, honoured only in IDLE
//   rom_addr    : address of the next sample to load
//   rom_dout    : ROM sample for rom_addr (same cycle)
//   out_data    : registered sample, I [31:16], Q [15:0]
//   out_valid   : out_data holds a valid sample
//   out_ready   : downstream accept
//   out_last    : marks sample 16*NUM_REP-1
//   busy        : sequence in progress
//   done        : one-cycle pulse after the last sample is accepted
module stf_sequencer
  import stf_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REP = 10
) (
  input  logic                  clk,
  input  logic                  phy_tx_arst,
  input  logic                  start,
  output logic [STF_ADDR_W-1:0] rom_addr,
  input  logic [IQ_W-1:0]       rom_dout,
  output logic [IQ_W-1:0]       out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [3:0] LAST_REP = 4'(NUM_REP - 1);

  state_t                  state;
  logic [STF_ADDR_W-1:0]   addr_cnt;
  logic [3:0]              rep_cnt;
  logic [STF_ADDR_W-1:0]   addr_nxt;
  logic [3:0]              rep_nxt;
  logic                    load_last;
  logic                    hs;
  logic [IQ_W-1:0]         sample;

  // Counters point at the sample about to be loaded, so rom_addr is
  // simply the address counter.
  assign rom_addr  = addr_cnt;
  assign hs        = out_valid && out_ready;
  assign load_last = (addr_cnt == '1) && (rep_cnt == LAST_REP);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

`ifdef STF_WINDOW_EN
  logic            load_first;
  logic [IQ_W-1:0] half;

  assign load_first = (addr_cnt == '0) && (rep_cnt == '0);

  iq_half_shift u_half (
    .din  (rom_dout),
    .dout (half)
  );

  assign sample = (load_first || load_last) ? half : rom_dout;
`else
  assign sample = rom_dout;
`endif

  // After the final sample is loaded the counters fall back to zero so the
  // next sequence starts at address 0 without an extra clear step.
  always_comb begin
    addr_nxt = addr_cnt + 1'b1;
    rep_nxt  = rep_cnt;
    if (load_last) begin
      addr_nxt = '0;
      rep_nxt  = '0;
    end else if (addr_cnt == '1) begin
      rep_nxt = rep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge phy_tx_arst) begin
    if (phy_tx_arst) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      rep_cnt   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            out_data  <= sample;
            out_valid <= 1'b1;
            out_last  <= load_last;
            addr_cnt  <= addr_nxt;
            rep_cnt   <= rep_nxt;
            state     <= RUN;
          end
        end
        RUN: begin
          if (hs) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= DONE;
            end else begin
              out_data <= sample;
              out_last <= load_last;
              addr_cnt <= addr_nxt;
              rep_cnt  <= rep_nxt;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stf_sequencer.sv
// tb_stf_sequencer
// Directed bench for stf_sequencer: one instance with NUM_REP=10 and one
// with NUM_REP=1, each fed by a combinational STF ROM model. Honours
// STF_WINDOW_EN for the expected first/last sample values.
module tb_stf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        sel;

  logic [3:0]  rom_addr_a, rom_addr_b;
  logic [31:0] rom_dout_a, rom_dout_b;
  logic [31:0] data_a, data_b;
  logic        valid_a, valid_b, last_a, last_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic        start_a, start_b, ready_a, ready_b;

  logic [31:0] m_data;
  logic        m_valid, m_last, m_busy, m_done;

  logic [31:0] seen [160];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h02f2_02f2;
      4'd1:    return 32'hfc27_0198;
      4'd2:    return 32'h0000_fbd6;
      4'd3:    return 32'h05d3_ff84;
      4'd4:    return 32'h03c4_0000;
      4'd5:    return 32'h0511_ff70;
      4'd6:    return 32'hff80_fb10;
      4'd7:    return 32'hfc10_0050;
      4'd8:    return 32'h02e0_0300;
      4'd9:    return 32'h0070_fc30;
      4'd10:   return 32'hfb00_ff90;
      4'd11:   return 32'hff60_05c0;
      4'd12:   return 32'h0010_03b0;
      4'd13:   return 32'hff50_05a0;
      4'd14:   return 32'hfb20_ff60;
      default: return 32'h0198_fc27;
    endcase
  endfunction

`ifdef STF_WINDOW_EN
  localparam logic [31:0] FIRST_EXP = 32'h0179_0179;
  localparam logic [31:0] LAST_EXP  = 32'h00cc_fe13;
`else
  localparam logic [31:0] FIRST_EXP = 32'h02f2_02f2;
  localparam logic [31:0] LAST_EXP  = 32'h0198_fc27;
`endif

  function automatic logic [31:0] exp_sample(input int idx, input int total);
    if (idx == 0) return FIRST_EXP;
    if (idx == total - 1) return LAST_EXP;
    return rom_val(4'(idx % 16));
  endfunction

  assign rom_dout_a = rom_val(rom_addr_a);
  assign rom_dout_b = rom_val(rom_addr_b);
  assign start_a    = start & ~sel;
  assign start_b    = start & sel;
  assign ready_a    = sel ? 1'b0 : ready;
  assign ready_b    = sel ? ready : 1'b0;
  assign m_data     = sel ? data_b  : data_a;
  assign m_valid    = sel ? valid_b : valid_a;
  assign m_last     = sel ? last_b  : last_a;
  assign m_busy     = sel ? busy_b  : busy_a;
  assign m_done     = sel ? done_b  : done_a;

  stf_sequencer #(.NUM_REP(10)) dut (
    .clk         (clk),
    .phy_tx_arst (rst),
    .start       (start_a),
    .rom_addr    (rom_addr_a),
    .rom_dout    (rom_dout_a),
    .out_data    (data_a),
    .out_valid   (valid_a),
    .out_ready   (ready_a),
    .out_last    (last_a),
    .busy        (busy_a),
    .done        (done_a)
  );

  stf_sequencer #(.NUM_REP(1)) dut1 (
    .clk         (clk),
    .phy_tx_arst (rst),
    .start       (start_b),
    .rom_addr    (rom_addr_b),
    .rom_dout    (rom_dout_b),
    .out_data    (data_b),
    .out_valid   (valid_b),
    .out_ready   (ready_b),
    .out_last    (last_b),
    .busy        (busy_b),
    .done        (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs at negedges: outputs are observed, ready/start chosen for the next
  // rising edge, and a sample is scored when it will be accepted there.
  // Returns at the negedge where done is seen, or where idx == stop_at.
  task automatic run_seq(input int total, input bit bp, input bit ign,
                         input bit do_start, input int stop_at);
    int          idx = 0;
    int          last_cyc = -100;
    bit          held = 1'b0;
    bit          fin = 1'b0;
    bit          p5 = 1'b0;
    bit          p100 = 1'b0;
    logic [31:0] pdata = '0;
    logic        plast = 1'b0;
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (idx == stop_at) begin
        fin = 1'b1;
        break;
      end
      start = 1'b0;
      if (held) begin
        check("hold_data", m_data, pdata);
        check("hold_valid", m_valid, 1'b1);
        check("hold_last", m_last, plast);
      end
      if (m_done) begin
        check("done_cycle", cyc - last_cyc, 1);
        check("done_count", idx, total);
        check("done_valid_busy", {m_valid, m_busy}, 2'b00);
        fin = 1'b1;
        break;
      end
      if (idx < total) check("valid_busy", {m_valid, m_busy}, 2'b11);
      ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ign && idx == 5 && !p5) begin
        start = 1'b1;
        p5 = 1'b1;
      end
      if (ign && idx == 100 && !p100) begin
        start = 1'b1;
        p100 = 1'b1;
      end
      held  = m_valid && !ready;
      pdata = m_data;
      plast = m_last;
      if (m_valid && ready) begin
        if (idx < total) begin
          check("sample", m_data, exp_sample(idx, total));
          check("last_flag", m_last, (idx == total - 1));
          seen[idx] = m_data;
          idx++;
          if (idx == total) last_cyc = cyc;
        end else begin
          check("extra_sample", m_valid, 1'b0);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("seq_timeout", {31'b0, fin}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 1'b0; start = 1'b0; ready = 1'b0; rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_data", data_a, 32'h0);
    check("rst_valid", valid_a, 1'b0);
    check("rst_last", last_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_addr", rom_addr_a, 4'h0);
    check("rst_valid_b", valid_b, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequence
    run_seq(160, 1'b0, 1'b0, 1'b1, -1);
    check("s0", seen[0], FIRST_EXP);
    check("s1", seen[1], 32'hfc27_0198);
    check("s2", seen[2], 32'h0000_fbd6);
    check("s15", seen[15], 32'h0198_fc27);
    check("s16", seen[16], 32'h02f2_02f2);
    check("s159", seen[159], LAST_EXP);
    @(negedge clk);
    check("done_one_cycle", {m_done, m_busy, m_valid}, 3'b000);

    // Backpressure
    run_seq(160, 1'b1, 1'b0, 1'b1, -1);
    ready = 1'b1;
    @(negedge clk);

    // Ignored starts, then start in the done cycle
    run_seq(160, 1'b0, 1'b1, 1'b1, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done", {m_valid, m_busy}, 2'b00);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_valid", {m_valid, m_busy}, 2'b11);
    check("restart_data", m_data, FIRST_EXP);

    // Reset mid-operation at sample #70
    run_seq(160, 1'b0, 1'b0, 1'b0, 70);
    #2 rst = 1'b1;
    #1;
    check("arst_data", data_a, 32'h0);
    check("arst_valid", valid_a, 1'b0);
    check("arst_last", last_a, 1'b0);
    check("arst_busy", busy_a, 1'b0);
    check("arst_addr", rom_addr_a, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", done_a, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {done_a, valid_a, busy_a}, 3'b000);
    run_seq(160, 1'b0, 1'b0, 1'b1, -1);
    @(negedge clk);

    // NUM_REP = 1 instance
    sel = 1'b1;
    @(negedge clk);
    run_seq(16, 1'b0, 1'b0, 1'b1, -1);
    check("r1_first", seen[0], FIRST_EXP);
    check("r1_last", seen[15], LAST_EXP);
    @(negedge clk);
    check("r1_idle", {m_done, m_busy, m_valid}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stf_sequencer.md
Name: stf_sequencer

Overview:
- Consumer of the 16-entry STF ROM (4-bit address, 32-bit packed sample).
- On a start pulse it drives the ROM address and replays the 16-sample short-training period NUM_REP times (160 samples by default).
- Each sample is registered onto a valid/ready sample stream toward the TX sample mux / IFFT-output merge stage.
- Sample packing is I in [31:16] and Q in [15:0], both two's complement.

Parameters:
- NUM_REP, 10, number of 16-sample periods emitted per start (1..15).

Ports:
- clk  input  1  single TX clock; all logic on the rising edge.
- phy_tx_arst  input  1  reset, asynchronous and active-high; clears all state immediately.
- start  input  1  one-cycle pulse that begins a sequence; honoured only in IDLE.
- rom_addr  output  4  address to the STF ROM, which is combinational (data returns in the same cycle).
- rom_dout  input  32  ROM sample for rom_addr.
- out_data  output  32  registered sample, I in [31:16] and Q in [15:0].
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_last  output  1  high with the final sample (index 16*NUM_REP-1).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse the cycle after the last sample is accepted.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, rom_addr=0. State=IDLE, counters=0.
- State IDLE:
  - start=1 loads the output register with rom_dout at address 0, sets out_valid=1 and busy=1, and enters RUN.
  - Latency: start at cycle N, so the first sample is valid at N+1.
- State RUN:
  - Counters: addr_cnt (4 bits, wraps 15->0) and rep_cnt (0..NUM_REP-1, increments when addr_cnt wraps).
  - rom_addr always equals the address of the next sample to load.
  - On each handshake that is not the last sample, the register loads the next sample in the same cycle. out_valid stays high, so there are no bubbles and throughput is 1 sample/cycle with out_ready tied high.
  - Without a handshake (out_ready=0), out_data, out_last and out_valid hold stable.
  - out_last=1 exactly when the registered sample is index 16*NUM_REP-1.
  - On a handshake of the last sample: out_valid drops next cycle and the block enters DONE.
- State DONE:
  - done=1 for one cycle and busy=0. Returns to IDLE on the next cycle.
- start while busy or in DONE is ignored; there is no queuing.
- A start in the same cycle as done is ignored; a new start is accepted from IDLE on the following cycle.
- Asserting reset mid-sequence aborts immediately: outputs return to reset values and no done pulse is produced.
- No arithmetic on samples except under the optional feature.

Optional Feature:
- Macro: STF_WINDOW_EN.
- When defined, the first sample (index 0) and the last sample (index 16*NUM_REP-1) are halved before registering. I and Q are each arithmetic-shifted right by 1 independently (sign-preserving, truncation toward -inf). This approximates 802.11 symbol-edge windowing.
- When undefined, samples pass through unmodified and there is no extra logic.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package holds:
  - STF_PERIOD=16 and STF_ADDR_W=4.
  - IQ sample width constant (32), with I/Q field positions.
  - State enum {IDLE, RUN, DONE}.
- Natural sub-module: iq_half_shift, a combinational per-component arithmetic >>1 used only under STF_WINDOW_EN.
- Counters and the FSM stay in stf_sequencer.
- The ROM is instantiated outside this block, in the parent.

Test Plan:
1. Basic sequence: reset, start with out_ready=1.
   - Samples 0/1/2 = 02f2_02f2 / fc27_0198 / 0000_fbd6.
   - Sample 15 = 0198_fc27 and sample 16 = 02f2_02f2.
   - Exactly 160 samples; out_last only on #159; done exactly one cycle after #159; busy low afterward.
2. Backpressure: out_ready toggled with a pseudo-random pattern.
   - The sequence still contains 160 samples in ROM order with no duplicates or drops.
   - out_data is stable whenever out_valid=1 and out_ready=0.
3. Ignored start: pulse start at samples #5 and #100.
   - The stream is unaffected; still 160 samples and one done.
   - A start in the done cycle is ignored; a start one cycle later begins a new sequence with 02f2_02f2.
4. Reset mid-operation: assert phy_tx_arst at sample #70.
   - All outputs read 0 asynchronously and no done pulse is produced.
   - After release, start produces a full 160-sample sequence from 02f2_02f2.
5. NUM_REP=1: 16 samples, out_last on sample 0198_fc27, then done.
6. STF_WINDOW_EN build: first sample 0179_0179 and last sample 00cc_fe13; all other samples are unmodified ROM values.
